// File: rtl/echo_meter_pkg.sv
// Shared definitions for the ultrasonic echo meter: FSM encoding and time-base helpers.
package echo_meter_pkg;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_TRIG      = 3'd1;
  localparam logic [2:0] ST_WAIT_RISE = 3'd2;
  localparam logic [2:0] ST_MEASURE   = 3'd3;
  localparam logic [2:0] ST_FINISH    = 3'd4;

  localparam int DEF_FREQ_IN    = 50_000_000;
  localparam int DEF_TICK_FREQ  = 1_000_000;
  localparam int DEF_TRIG_US    = 10;
  localparam int DEF_TIMEOUT_US = 30_000;

  localparam int DIV      = DEF_FREQ_IN / DEF_TICK_FREQ;
  localparam int DIV_W    = $clog2(DIV);
  localparam int TRIG_CYC = DEF_TRIG_US * DIV;

  function automatic int calc_div(input int freq_in, input int tick_freq);
    return freq_in / tick_freq;
  endfunction

endpackage

// File: rtl/echo_meter_tick_gen.sv
// Prescaler producing a one-cycle tick enable every FREQ_IN/TICK_FREQ clocks.
module tick_gen
  import echo_meter_pkg::*;
#(
  parameter int FREQ_IN   = DEF_FREQ_IN,
  parameter int TICK_FREQ = DEF_TICK_FREQ
) (
  input  logic CLK_IN,
  input  logic RST_N,
  input  logic CLR,
  output logic TICK
);

  localparam int L_DIV   = calc_div(FREQ_IN, TICK_FREQ);
  localparam int L_DIV_W = $clog2(L_DIV);

  logic [L_DIV_W-1:0] r_cnt;

  // Wrap value flags the tick; CLR restarts the period so the first tick lands L_DIV cycles later
  assign TICK = (r_cnt == L_DIV_W'(L_DIV - 1));

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt <= '0;
    end else if (CLR || TICK) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/echo_meter.sv
// Ultrasonic ranging front end: fires a trigger pulse, then times the echo high-time in ticks.
module echo_meter
  import echo_meter_pkg::*;
#(
  parameter int FREQ_IN    = DEF_FREQ_IN,
  parameter int TICK_FREQ  = DEF_TICK_FREQ,
  parameter int TRIG_US    = DEF_TRIG_US,
  parameter int TIMEOUT_US = DEF_TIMEOUT_US,
  parameter int WIDTH      = 16
) (
  input  logic             CLK_IN,
  input  logic             RST_N,
  input  logic             START,
  input  logic             ECHO,
  output logic             TRIG,
  output logic             BUSY,
  output logic             DONE,
  output logic             TIMEOUT,
  output logic [WIDTH-1:0] WIDTH_US
);

  logic [2:0]       r_state;
  logic [2:0]       w_state_nxt;
  logic [WIDTH-1:0] r_cnt;
  logic [WIDTH-1:0] w_cnt_inc;
  logic [WIDTH-1:0] r_width;
  logic [WIDTH-1:0] w_width_nxt;
  logic             r_echo_s1;
  logic             r_echo_s2;
  logic             r_echo_d;
  logic             r_trig;
  logic             r_done;
  logic             r_timeout;
  logic             w_tmo_nxt;
  logic             w_tick;
  logic             w_state_chg;
  logic             w_rise;
  logic             w_fall;
  logic             w_trig_end;
  logic             w_limit;

  tick_gen #(
    .FREQ_IN   (FREQ_IN),
    .TICK_FREQ (TICK_FREQ)
  ) u_tick_gen (
    .CLK_IN (CLK_IN),
    .RST_N  (RST_N),
    .CLR    (w_state_chg),
    .TICK   (w_tick)
  );

  assign w_rise      = r_echo_s2 & ~r_echo_d;
  assign w_fall      = ~r_echo_s2 & r_echo_d;
  // A tick landing in the decision cycle is counted, giving floor(high-time / tick period)
  assign w_cnt_inc   = r_cnt + WIDTH'(w_tick);
  assign w_trig_end  = w_tick && (r_cnt == WIDTH'(TRIG_US - 1));
  assign w_limit     = w_tick && (r_cnt == WIDTH'(TIMEOUT_US - 1));
  assign w_state_chg = (w_state_nxt != r_state);

  always_comb begin
    w_state_nxt = r_state;
    w_tmo_nxt   = 1'b0;
    w_width_nxt = r_width;
    case (r_state)
      ST_IDLE: begin
        if (START) w_state_nxt = ST_TRIG;
      end
      ST_TRIG: begin
        if (w_trig_end) w_state_nxt = ST_WAIT_RISE;
      end
      ST_WAIT_RISE: begin
        if (w_rise) begin
          w_state_nxt = ST_MEASURE;
        end else if (w_limit) begin
          w_state_nxt = ST_FINISH;
          w_tmo_nxt   = 1'b1;
          w_width_nxt = '0;
        end
      end
      ST_MEASURE: begin
        // Falling edge takes priority over a coincident timeout tick
        if (w_fall) begin
          w_state_nxt = ST_FINISH;
          w_width_nxt = w_cnt_inc;
        end else if (w_limit) begin
          w_state_nxt = ST_FINISH;
          w_tmo_nxt   = 1'b1;
          w_width_nxt = WIDTH'(TIMEOUT_US);
        end
      end
      ST_FINISH: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK_IN or negedge RST_N) begin
    if (!RST_N) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_width   <= '0;
      r_echo_s1 <= 1'b0;
      r_echo_s2 <= 1'b0;
      r_echo_d  <= 1'b0;
      r_trig    <= 1'b0;
      r_done    <= 1'b0;
      r_timeout <= 1'b0;
    end else begin
      r_echo_s1 <= ECHO;
      r_echo_s2 <= r_echo_s1;
      r_echo_d  <= r_echo_s2;
      r_state   <= w_state_nxt;
      r_cnt     <= w_state_chg ? '0 : w_cnt_inc;
      r_width   <= w_width_nxt;
      r_trig    <= (w_state_nxt == ST_TRIG);
      r_done    <= (w_state_nxt == ST_FINISH);
      r_timeout <= w_tmo_nxt;
    end
  end

  assign TRIG     = r_trig;
  assign BUSY     = (r_state != ST_IDLE);
  assign DONE     = r_done;
  assign TIMEOUT  = r_timeout;
  assign WIDTH_US = r_width;

endmodule
